// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store unit: decodes MIPS byte/half/word loads and stores and
// drives a request/acknowledge data port with lane-aligned data and byte enables.
module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [31:0]       ins_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [31:0]       wdata_in,
   output logic              ready_out,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       rdata_out,
   output logic              rdata_valid,
   output logic              sw,
   output logic              misalign_err,
   output logic              timeout_err
);
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Counter only ever needs to hold 0..TIMEOUT-1; abort fires on the last value.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [0:0]        state_reg;
   logic [5:0]        op_reg;
   logic [1:0]        off_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [3:0]        be_reg;
   logic [31:0]       wdata_reg;
   logic              we_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [31:0]       rdata_reg;
   logic              rvalid_reg;
   logic              mis_reg;
   logic              to_reg;

   logic [5:0]  op_dec;
   logic        is_mem;
   logic        is_store;
   logic [1:0]  size_dec;
   logic        aligned;
   logic [3:0]  be_dec;
   logic [31:0] wdata_dec;
   logic [7:0]  rd_byte [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_data;
   logic        unused_ins;

   assign op_dec     = ins_in[31:26];
   assign unused_ins = ^ins_in[25:0];

   always_comb begin
      is_mem   = 1'b1;
      is_store = 1'b0;
      size_dec = SZ_BYTE;
      case (op_dec)
         OP_LB, OP_LBU: size_dec = SZ_BYTE;
         OP_LH, OP_LHU: size_dec = SZ_HALF;
         OP_LW:         size_dec = SZ_WORD;
         OP_SB: begin
            is_store = 1'b1;
            size_dec = SZ_BYTE;
         end
         OP_SH: begin
            is_store = 1'b1;
            size_dec = SZ_HALF;
         end
         OP_SW: begin
            is_store = 1'b1;
            size_dec = SZ_WORD;
         end
         default: is_mem = 1'b0;
      endcase
   end

   always_comb begin
      aligned = 1'b1;
      be_dec  = 4'b1111;
      case (size_dec)
         SZ_BYTE: be_dec = 4'b0001 << addr_in[1:0];
         SZ_HALF: begin
            be_dec  = 4'b0011 << addr_in[1:0];
            aligned = ~addr_in[0];
         end
         default: aligned = (addr_in[1:0] == 2'b00);
      endcase
   end

   // Per-lane store replication and read-lane split.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_dec[8*gi +: 8] = (size_dec == SZ_BYTE) ? wdata_in[7:0] :
                                    (size_dec == SZ_HALF) ? wdata_in[8*(gi%2) +: 8] :
                                                            wdata_in[8*gi +: 8];
      assign rd_byte[gi] = mem_rdata[8*gi +: 8];
   end

   always_comb begin
      sel_byte = rd_byte[off_reg];
      sel_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_reg)
         OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
         OP_LBU:  load_data = {24'd0, sel_byte};
         OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
         OP_LHU:  load_data = {16'd0, sel_half};
         default: load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         op_reg     <= '0;
         off_reg    <= '0;
         addr_reg   <= '0;
         be_reg     <= '0;
         wdata_reg  <= '0;
         we_reg     <= 1'b0;
         cnt_reg    <= '0;
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
         mis_reg    <= 1'b0;
         to_reg     <= 1'b0;
      end else begin
         rvalid_reg <= 1'b0;
         mis_reg    <= 1'b0;
         to_reg     <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (valid_in && is_mem) begin
                  if (aligned) begin
                     op_reg    <= op_dec;
                     off_reg   <= addr_in[1:0];
                     addr_reg  <= {addr_in[ADDR_W-1:2], 2'b00};
                     be_reg    <= be_dec;
                     wdata_reg <= wdata_dec;
                     we_reg    <= is_store;
                     cnt_reg   <= '0;
                     state_reg <= ST_BUSY;
                  end else begin
                     mis_reg <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               // An ack in the final counted cycle wins over the timeout.
               if (mem_ack) begin
                  state_reg <= ST_IDLE;
                  if (!we_reg) begin
                     rdata_reg  <= load_data;
                     rvalid_reg <= 1'b1;
                  end
               end else if (TIMEOUT != 0 && cnt_reg == TO_LAST) begin
                  state_reg <= ST_IDLE;
                  to_reg    <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign ready_out    = (state_reg == ST_IDLE);
   assign mem_req      = (state_reg == ST_BUSY);
   assign mem_we       = we_reg;
   assign mem_be       = be_reg;
   assign mem_addr     = addr_reg;
   assign mem_wdata    = wdata_reg;
   assign rdata_out    = rdata_reg;
   assign rdata_valid  = rvalid_reg;
   assign misalign_err = mis_reg;
   assign timeout_err  = to_reg;
   assign sw = (state_reg == ST_BUSY) ? (op_reg == OP_SW) : (valid_in && op_dec == OP_SW);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic checked
// against a byte-addressed reference memory.
module tb_mem_access_ctrl;
   localparam int TO = 4;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] ins_in, addr_in, wdata_in;
   logic        ready_out, mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata, rdata_out;
   logic        rdata_valid, sw, misalign_err, timeout_err;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ins_in(ins_in),
      .addr_in(addr_in), .wdata_in(wdata_in), .ready_out(ready_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rdata_out(rdata_out), .rdata_valid(rdata_valid), .sw(sw),
      .misalign_err(misalign_err), .timeout_err(timeout_err)
   );

   int total = 0;
   int bad = 0;
   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   logic [31:0] mem_words [16];
   logic [7:0]  ref_bytes [64];

   int          obs_req, obs_rv, obs_mis, obs_to;
   logic        obs_ready_bad, obs_unstable, obs_sw, obs_we;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;

   function automatic int op_size(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return (op == OP_SB || op == OP_SH || op == OP_SW);
   endfunction

   function automatic logic [3:0] ref_be(input int size, input int a);
      return 4'(((1 << size) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] ref_wd(input int size, input logic [31:0] wd);
      if (size == 1) return 32'(wd[7:0]) * 32'h01010101;
      if (size == 2) return 32'(wd[15:0]) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [5:0] op, input int a);
      int size = op_size(op);
      logic [31:0] v = '0;
      for (int k = 0; k < size; k++) v = v | (32'(ref_bytes[a + k]) << (8 * k));
      if ((op == OP_LB || op == OP_LH) && v[8 * size - 1]) v = v | (32'hFFFFFFFF << (8 * size));
      return v;
   endfunction

   // Presents one instruction, plays the memory side, records what the DUT did.
   task automatic access(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits);
      int n;
      obs_req = 0; obs_rv = 0; obs_mis = 0; obs_to = 0;
      obs_ready_bad = 1'b0; obs_unstable = 1'b0; obs_rdata = '0;
      valid_in = 1'b1; ins_in = {op, 26'($urandom)}; addr_in = addr; wdata_in = wd;
      #1 obs_sw = sw;
      @(posedge clk); #1;
      valid_in = 1'b0; ins_in = $urandom; addr_in = $urandom; wdata_in = $urandom;
      if (misalign_err) obs_mis++;
      obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
      n = 0;
      while (mem_req && n < 40) begin
         obs_req++;
         if (ready_out) obs_ready_bad = 1'b1;
         if (mem_be !== obs_be || mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_we !== obs_we)
            obs_unstable = 1'b1;
         if (waits >= 0 && n >= waits) begin
            mem_ack = 1'b1;
            mem_rdata = mem_words[mem_addr[5:2]];
            if (mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem_words[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
         @(posedge clk); #1;
         mem_ack = 1'b0; mem_rdata = $urandom;
         n++;
         if (rdata_valid) begin obs_rv++; obs_rdata = rdata_out; end
         if (timeout_err) obs_to++;
         if (misalign_err) obs_mis++;
      end
      if (!ready_out) obs_ready_bad = 1'b1;
      $display("txn op=%b addr=%h wd=%h req=%0d be=%b rv=%0d rdata=%h mis=%0d to=%0d",
               op, addr, wd, obs_req, obs_be, obs_rv, obs_rdata, obs_mis, obs_to);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_out); end
      total++; if ({mem_req, mem_we, mem_be, rdata_valid, misalign_err, timeout_err} !== 9'd0) begin bad++;
         $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_be, rdata_valid, misalign_err, timeout_err}); end
      total++; if ({rdata_out, mem_addr, mem_wdata} !== 96'd0) begin bad++;
         $display("FAIL reset_data: got %h want 0", {rdata_out, mem_addr, mem_wdata}); end
      reset = 1'b0;
      mem_words[0] = 32'h12345678;
      access(OP_LW, 32'h100, 32'h0, 0);
      total++; if (rdata_out !== 32'h12345678) begin bad++; $display("FAIL reset_preload: got %h want 12345678", rdata_out); end
      valid_in = 1'b1; ins_in = {OP_SW, 26'd0}; addr_in = 32'h104; wdata_in = 32'h55;
      @(posedge clk); #1;
      valid_in = 1'b0;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_busy: got req=%b want 1", mem_req); end
      #2 reset = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0 || ready_out !== 1'b1) begin bad++;
         $display("FAIL reset_async: got req=%b ready=%b want 0/1", mem_req, ready_out); end
      total++; if (rdata_out !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata_out); end
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      total++; if ({mem_req, rdata_valid, misalign_err, timeout_err} !== 4'd0) begin bad++;
         $display("FAIL reset_quiet: got %b want 0000", {mem_req, rdata_valid, misalign_err, timeout_err}); end
   endtask

   task automatic test_store_word();
      mem_words[0] = 32'h0;
      access(OP_SW, 32'h100, 32'hDEADBEEF, 2);
      total++; if (obs_sw !== 1'b1) begin bad++; $display("FAIL sw_flag: got %b want 1", obs_sw); end
      total++; if (obs_be !== 4'b1111 || obs_we !== 1'b1) begin bad++; $display("FAIL sw_be: got be=%b we=%b want 1111/1", obs_be, obs_we); end
      total++; if (obs_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", obs_wdata); end
      total++; if (obs_addr !== 32'h100) begin bad++; $display("FAIL sw_addr: got %h want 100", obs_addr); end
      total++; if (obs_req !== 3) begin bad++; $display("FAIL sw_req_cycles: got %0d want 3", obs_req); end
      total++; if (obs_ready_bad || obs_unstable || obs_rv != 0) begin bad++;
         $display("FAIL sw_hold: got ready_bad=%b unstable=%b rv=%0d want 0/0/0", obs_ready_bad, obs_unstable, obs_rv); end
      total++; if (mem_words[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem: got %h want deadbeef", mem_words[0]); end
   endtask

   task automatic test_store_byte();
      mem_words[0] = 32'h0;
      access(OP_SB, 32'h103, 32'h000000A5, 1);
      total++; if (obs_be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", obs_be); end
      total++; if (obs_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); end
      total++; if (obs_addr !== 32'h100 || obs_sw !== 1'b0) begin bad++; $display("FAIL sb_addr: got %h sw=%b want 100/0", obs_addr, obs_sw); end
      total++; if (obs_req !== 2 || obs_rv != 0) begin bad++; $display("FAIL sb_req: got req=%0d rv=%0d want 2/0", obs_req, obs_rv); end
   endtask

   task automatic test_load_ext();
      logic [5:0]  ops  [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
      logic [31:0] adrs [4] = '{32'h102, 32'h102, 32'h102, 32'h100};
      logic [31:0] exps [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h00007F11};
      for (int i = 0; i < 4; i++) begin
         mem_words[0] = 32'h80F07F11;
         access(ops[i], adrs[i], 32'h0, i % 3);
         total++; if (obs_rv !== 1) begin bad++; $display("FAIL ld_pulse[%0d]: got %0d want 1", i, obs_rv); end
         total++; if (obs_rdata !== exps[i]) begin bad++; $display("FAIL ld_data[%0d]: got %h want %h", i, obs_rdata, exps[i]); end
      end
   endtask

   task automatic test_misalign();
      logic [5:0]  ops  [2] = '{OP_LW, OP_SH};
      logic [31:0] adrs [2] = '{32'h102, 32'h101};
      for (int i = 0; i < 2; i++) begin
         access(ops[i], adrs[i], 32'h1234, 0);
         total++; if (obs_mis !== 1) begin bad++; $display("FAIL mis_pulse[%0d]: got %0d want 1", i, obs_mis); end
         total++; if (obs_req !== 0 || obs_ready_bad) begin bad++;
            $display("FAIL mis_noreq[%0d]: got req=%0d ready_bad=%b want 0/0", i, obs_req, obs_ready_bad); end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] held;
      held = rdata_out;
      access(OP_LW, 32'h100, 32'h0, -1);
      total++; if (obs_req !== TO) begin bad++; $display("FAIL to_req_cycles: got %0d want %0d", obs_req, TO); end
      total++; if (obs_to !== 1 || obs_rv != 0) begin bad++; $display("FAIL to_pulse: got to=%0d rv=%0d want 1/0", obs_to, obs_rv); end
      total++; if (rdata_out !== held || ready_out !== 1'b1) begin bad++;
         $display("FAIL to_hold: got rdata=%h ready=%b want %h/1", rdata_out, ready_out, held); end
      mem_words[0] = 32'h0BADF00D;
      access(OP_LW, 32'h100, 32'h0, 0);
      total++; if (obs_rv !== 1 || obs_rdata !== 32'h0BADF00D || obs_to != 0) begin bad++;
         $display("FAIL to_recover: got rv=%0d rdata=%h to=%0d want 1/0badf00d/0", obs_rv, obs_rdata, obs_to); end
      access(OP_LW, 32'h100, 32'h0, TO - 1);
      total++; if (obs_to !== 0 || obs_rv !== 1 || obs_req !== TO) begin bad++;
         $display("FAIL to_last_ack: got to=%0d rv=%0d req=%0d want 0/1/%0d", obs_to, obs_rv, obs_req, TO); end
   endtask

   task automatic test_idle_ack();
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (mem_req !== 1'b0 || rdata_valid !== 1'b0) begin bad++;
            $display("FAIL idle_ack[%0d]: got req=%b rv=%b want 0/0", i, mem_req, rdata_valid); end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      int start;
      start = cyc_cnt;
      for (int i = 0; i < 4; i++) begin
         mem_words[1] = 32'hCAFE0000 + 32'(i);
         access(OP_LW, 32'h104, 32'h0, 0);
         total++; if (obs_rdata !== 32'hCAFE0000 + 32'(i)) begin bad++;
            $display("FAIL b2b_data[%0d]: got %h want %h", i, obs_rdata, 32'hCAFE0000 + 32'(i)); end
      end
      total++; if (cyc_cnt - start > 12) begin bad++; $display("FAIL b2b_rate: got %0d cycles want <=12", cyc_cnt - start); end
   endtask

   task automatic test_random();
      logic [5:0] mem_ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
      logic [5:0] oth_ops [4] = '{6'b000000, 6'b001000, 6'b100010, 6'b101010};
      logic [31:0] w;
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         mem_words[i] = w;
         for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
      end
      for (int t = 0; t < 200; t++) begin
         int r, a, size, waits;
         logic [5:0]  op;
         logic [31:0] wd;
         r = $urandom_range(0, 9);
         op = (r < 8) ? mem_ops[r] : oth_ops[$urandom_range(0, 3)];
         a = $urandom_range(0, 63);
         wd = $urandom;
         waits = $urandom_range(0, 3);
         size = op_size(op);
         access(op, 32'(a), wd, waits);
         total++; if (obs_sw !== (op == OP_SW)) begin bad++; $display("FAIL rnd_sw[%0d]: got %b want %b", t, obs_sw, op == OP_SW); end
         if (size == 0) begin
            total++; if (obs_req != 0 || obs_mis != 0 || obs_rv != 0) begin bad++;
               $display("FAIL rnd_nonmem[%0d]: got req=%0d mis=%0d rv=%0d want 0", t, obs_req, obs_mis, obs_rv); end
         end else if (a % size != 0) begin
            total++; if (obs_mis != 1 || obs_req != 0) begin bad++;
               $display("FAIL rnd_mis[%0d]: got mis=%0d req=%0d want 1/0", t, obs_mis, obs_req); end
         end else begin
            total++; if (obs_req != waits + 1 || obs_to != 0 || obs_unstable) begin bad++;
               $display("FAIL rnd_req[%0d]: got req=%0d to=%0d unstable=%b want %0d/0/0", t, obs_req, obs_to, obs_unstable, waits + 1); end
            total++; if (obs_be !== ref_be(size, a) || obs_addr !== 32'(a & ~3) || obs_we !== op_store(op)) begin bad++;
               $display("FAIL rnd_port[%0d]: got be=%b addr=%h we=%b want %b/%h/%b", t, obs_be, obs_addr, obs_we,
                        ref_be(size, a), 32'(a & ~3), op_store(op)); end
            if (op_store(op)) begin
               total++; if (obs_wdata !== ref_wd(size, wd) || obs_rv != 0) begin bad++;
                  $display("FAIL rnd_st[%0d]: got wdata=%h rv=%0d want %h/0", t, obs_wdata, obs_rv, ref_wd(size, wd)); end
               for (int k = 0; k < size; k++) ref_bytes[a + k] = wd[8*k +: 8];
            end else begin
               total++; if (obs_rv != 1 || obs_rdata !== ref_load(op, a)) begin bad++;
                  $display("FAIL rnd_ld[%0d]: got rv=%0d rdata=%h want 1/%h", t, obs_rv, obs_rdata, ref_load(op, a)); end
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; valid_in = 1'b0; ins_in = '0; addr_in = '0; wdata_in = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 16; i++) mem_words[i] = '0;
      test_reset();
      test_store_word();
      test_store_byte();
      test_load_ext();
      test_misalign();
      test_timeout();
      test_idle_ack();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
